// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package fetch_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   localparam int unsigned DEF_ADDR_W   = 4;
   localparam int unsigned DEF_INSTR_W  = 4;
   localparam logic [3:0]  DEF_NOP_CODE = 4'h0;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_unit_if.sv
// Control, program-load and instruction-issue bundle between the
// controlling agent (master) and the fetch unit (slave).
interface instruction_fetch_unit_if #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned INSTR_W = 4
);
   logic               prog_we;
   logic [ADDR_W-1:0]  prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic [ADDR_W-1:0]  end_addr;
   logic               start;
   logic               stall;
   logic               abort;
   logic [INSTR_W-1:0] instruction;
   logic               instr_valid;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               done;

   modport master (
      output prog_we, prog_addr, prog_data, end_addr, start, stall, abort,
      input  instruction, instr_valid, pc, busy, done
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, end_addr, start, stall, abort,
      output instruction, instr_valid, pc, busy, done
   );
endinterface : instruction_fetch_unit_if

// File: rtl/instruction_fetch_unit_mem.sv
// Program store: synchronous write, synchronous read, no reset on the array.
module instr_mem #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned INSTR_W = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [INSTR_W-1:0] mem_r [DEPTH];
   logic [INSTR_W-1:0] rdata_r;

   // Array write and registered read; a read in the same edge as a write
   // returns the old contents, so new data is visible from the next edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
      rdata_r <= mem_r[raddr];
   end

   assign rdata = rdata_r;

endmodule : instr_mem

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable program store, program counter and a
// three-state sequencer issuing one instruction per cycle to the processor.
// The store read register doubles as the instruction register; whenever no
// real fetch was issued the output is replaced by NOP_CODE.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEF_ADDR_W,
   parameter int unsigned       INSTR_W  = DEF_INSTR_W,
   parameter logic [INSTR_W-1:0] NOP_CODE = DEF_NOP_CODE,
   parameter bit                LOOP_EN  = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   instruction_fetch_unit_if.slave   bus
);

   fetch_state_t       state_r, state_nxt_s;
   logic [ADDR_W-1:0]  pc_r, pc_nxt_s;
   logic [ADDR_W-1:0]  end_q_r, end_q_nxt_s;
   logic               valid_r, valid_nxt_s;
   logic               busy_r, done_r;
   logic               mem_we_s;
   logic [INSTR_W-1:0] rdata_s;

   // Program loading is locked out while a program is running.
   assign mem_we_s = bus.prog_we && (state_r != RUN);

   instr_mem #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_data),
      .raddr (pc_r),
      .rdata (rdata_s)
   );

   // Next-state, next-PC and issue-valid decode; abort > start > stall > normal.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      end_q_nxt_s = end_q_r;
      valid_nxt_s = 1'b0;
      if (bus.abort) begin
         state_nxt_s = IDLE;
         pc_nxt_s    = {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_nxt_s = RUN;
                  pc_nxt_s    = {ADDR_W{1'b0}};
                  end_q_nxt_s = bus.end_addr;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            RUN: begin
               if (bus.stall) begin
                  valid_nxt_s = 1'b0;
               end else begin
                  valid_nxt_s = 1'b1;
                  if (pc_r == end_q_r) begin
                     if (LOOP_EN) begin
                        pc_nxt_s = {ADDR_W{1'b0}};
                     end else begin
                        state_nxt_s = DONE;
                     end
                  end else begin
                     pc_nxt_s = pc_r + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_nxt_s = IDLE;
               pc_nxt_s    = {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // Sequencer state, PC, captured end address and output flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         pc_r    <= {ADDR_W{1'b0}};
         end_q_r <= {ADDR_W{1'b0}};
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         end_q_r <= end_q_nxt_s;
         valid_r <= valid_nxt_s;
         busy_r  <= (state_nxt_s == RUN);
         done_r  <= (state_nxt_s == DONE);
      end
   end

   assign bus.instruction = valid_r ? rdata_s : NOP_CODE;
   assign bus.instr_valid = valid_r;
   assign bus.pc          = pc_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: one non-looping and one
// looping instance, expected issues queued by stimulus, popped by monitors.
module tb_instruction_fetch_unit;

   typedef struct packed {
      logic [3:0] instr;
      logic       done;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t q1[$];
   exp_t q2[$];

   instruction_fetch_unit_if #(.ADDR_W(4), .INSTR_W(4)) bus1();
   instruction_fetch_unit_if #(.ADDR_W(4), .INSTR_W(4)) bus2();

   instruction_fetch_unit #(
      .ADDR_W(4), .INSTR_W(4), .NOP_CODE(4'h0), .LOOP_EN(1'b0)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   instruction_fetch_unit #(
      .ADDR_W(4), .INSTR_W(4), .NOP_CODE(4'h0), .LOOP_EN(1'b1)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor for the non-looping instance
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus1.instr_valid) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1_unexpected actual=%0h required=none", bus1.instruction);
         end else begin
            e = q1.pop_front();
            chk("dut1_instr", 32'(bus1.instruction), 32'(e.instr));
            chk("dut1_done",  32'(bus1.done),        32'(e.done));
         end
      end
   end

   // Monitor for the looping instance
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus2.instr_valid) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut2_unexpected actual=%0h required=none", bus2.instruction);
         end else begin
            e = q2.pop_front();
            chk("dut2_instr", 32'(bus2.instruction), 32'(e.instr));
            chk("dut2_done",  32'(bus2.done),        32'(e.done));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr1(input logic [3:0] a, input logic [3:0] d);
      bus1.prog_we = 1'b1; bus1.prog_addr = a; bus1.prog_data = d;
      tick();
      bus1.prog_we = 1'b0;
   endtask

   task automatic wr2(input logic [3:0] a, input logic [3:0] d);
      bus2.prog_we = 1'b1; bus2.prog_addr = a; bus2.prog_data = d;
      tick();
      bus2.prog_we = 1'b0;
   endtask

   task automatic push_prog1(input logic [3:0] first);
      q1.push_back({first, 1'b0});
      q1.push_back({4'h5, 1'b0});
      q1.push_back({4'hA, 1'b0});
      q1.push_back({4'hF, 1'b1});
   endtask

   // Pulse start on dut1 then let the 4-instruction program finish.
   task automatic run1();
      bus1.end_addr = 4'd3; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      repeat (5) tick();
   endtask

   task automatic check_idle1(input string tag, input logic [3:0] exp_pc, input logic exp_done);
      @(negedge clk);
      chk({tag, "_instr"}, 32'(bus1.instruction), 32'h0);
      chk({tag, "_valid"}, 32'(bus1.instr_valid), 32'h0);
      chk({tag, "_pc"},    32'(bus1.pc),          32'(exp_pc));
      chk({tag, "_done"},  32'(bus1.done),        32'(exp_done));
      chk({tag, "_busy"},  32'(bus1.busy),        32'h0);
      chk({tag, "_q1"},    32'(q1.size()),        32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus1.prog_we = 1'b0; bus1.prog_addr = 4'd0; bus1.prog_data = 4'd0;
      bus1.end_addr = 4'd0; bus1.start = 1'b0; bus1.stall = 1'b0; bus1.abort = 1'b0;
      bus2.prog_we = 1'b0; bus2.prog_addr = 4'd0; bus2.prog_data = 4'd0;
      bus2.end_addr = 4'd0; bus2.start = 1'b0; bus2.stall = 1'b0; bus2.abort = 1'b0;
      #12;
      chk("rst_instr", 32'(bus1.instruction), 32'h0);
      chk("rst_valid", 32'(bus1.instr_valid), 32'h0);
      chk("rst_pc",    32'(bus1.pc),          32'h0);
      chk("rst_busy",  32'(bus1.busy),        32'h0);
      chk("rst_done",  32'(bus1.done),        32'h0);
      rst_n = 1'b1;
      tick();

      // Basic program run
      wr1(4'd0, 4'h1); wr1(4'd1, 4'h5); wr1(4'd2, 4'hA); wr1(4'd3, 4'hF);
      push_prog1(4'h1);
      run1();
      check_idle1("basic_after", 4'd3, 1'b1);

      // One-cycle stall after the second instruction
      push_prog1(4'h1);
      bus1.end_addr = 4'd3; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      tick(); tick();
      bus1.stall = 1'b1;
      tick();
      bus1.stall = 1'b0;
      @(negedge clk);
      chk("stall_valid", 32'(bus1.instr_valid), 32'h0);
      chk("stall_instr", 32'(bus1.instruction), 32'h0);
      chk("stall_pc",    32'(bus1.pc),          32'h2);
      chk("stall_busy",  32'(bus1.busy),        32'h1);
      tick(); tick(); tick();
      check_idle1("stall_after", 4'd3, 1'b1);

      // Writes during RUN are ignored; program replays unchanged
      push_prog1(4'h1);
      bus1.end_addr = 4'd3; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      bus1.prog_we = 1'b1; bus1.prog_addr = 4'd2; bus1.prog_data = 4'h9;
      tick();
      bus1.prog_we = 1'b0;
      repeat (4) tick();
      check_idle1("runwr_after", 4'd3, 1'b1);
      push_prog1(4'h1);
      run1();
      check_idle1("runwr_replay", 4'd3, 1'b1);

      // Abort from DONE, then write in IDLE together with start
      bus1.abort = 1'b1;
      tick();
      bus1.abort = 1'b0;
      check_idle1("abort_done", 4'd0, 1'b0);
      push_prog1(4'hC);
      bus1.prog_we = 1'b1; bus1.prog_addr = 4'd0; bus1.prog_data = 4'hC;
      bus1.end_addr = 4'd3; bus1.start = 1'b1;
      tick();
      bus1.prog_we = 1'b0; bus1.start = 1'b0;
      repeat (5) tick();
      check_idle1("wrstart_after", 4'd3, 1'b1);
      wr1(4'd0, 4'h1);

      // Asynchronous reset mid-RUN at pc=2, then replay
      q1.push_back({4'h1, 1'b0});
      q1.push_back({4'h5, 1'b0});
      bus1.end_addr = 4'd3; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("prerst_pc", 32'(bus1.pc), 32'h2);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_instr", 32'(bus1.instruction), 32'h0);
      chk("midrst_valid", 32'(bus1.instr_valid), 32'h0);
      chk("midrst_busy",  32'(bus1.busy),        32'h0);
      chk("midrst_pc",    32'(bus1.pc),          32'h0);
      chk("midrst_q1",    32'(q1.size()),        32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      push_prog1(4'h1);
      run1();
      check_idle1("rst_replay", 4'd3, 1'b1);

      // Looping instance: 3,7 repeating, done never set, abort returns to IDLE
      wr2(4'd0, 4'h3); wr2(4'd1, 4'h7);
      for (int i = 0; i < 3; i++) begin
         q2.push_back({4'h3, 1'b0});
         q2.push_back({4'h7, 1'b0});
      end
      bus2.end_addr = 4'd1; bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      repeat (6) tick();
      bus2.abort = 1'b1;
      tick();
      bus2.abort = 1'b0;
      @(negedge clk);
      chk("loop_abort_valid", 32'(bus2.instr_valid), 32'h0);
      chk("loop_abort_pc",    32'(bus2.pc),          32'h0);
      chk("loop_abort_busy",  32'(bus2.busy),        32'h0);
      chk("loop_abort_done",  32'(bus2.done),        32'h0);
      chk("loop_abort_instr", 32'(bus2.instruction), 32'h0);
      chk("loop_q2",          32'(q2.size()),        32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream stage of the 4-bit processor: holds a small loadable program store and a program counter.
- Presents one instruction per cycle on the processor's 4-bit instruction input.
- Start/stall/abort control, with optional loop-back at a programmable end address.
- Substitutes a NOP encoding whenever no valid instruction is issued.

Parameters:
- ADDR_W, 4: program-counter / store address width; store depth = 2**ADDR_W.
- INSTR_W, 4: instruction width; must match the processor's instruction input.
- NOP_CODE, 4'h0: value driven on instruction whenever instr_valid=0.
- LOOP_EN, 0: 1 = wrap PC to 0 after end address instead of entering DONE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prog_we  in  1  program store write enable.
- prog_addr  in  ADDR_W  program store write address.
- prog_data  in  INSTR_W  program store write data.
- end_addr  in  ADDR_W  last address of program; captured on start.
- start  in  1  level-sampled; launches fetch from address 0.
- stall  in  1  hold PC, issue NOP this cycle.
- abort  in  1  return to IDLE immediately.
- instruction  out  INSTR_W  registered instruction to processor.
- instr_valid  out  1  instruction is a real fetch (not NOP fill).
- pc  out  ADDR_W  address of the next fetch.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, end_q=0, instruction=NOP_CODE, instr_valid=0, busy=0, done=0. Store contents are not reset.
- Store: synchronous write, synchronous read, depth 2**ADDR_W.
  - Writes are accepted only in IDLE or DONE; prog_we is ignored in RUN.
  - A write at edge k is visible to a read at edge k+1 or later.
- FSM states: IDLE, RUN, DONE. Priority at each edge: abort > start > stall > normal.
- IDLE:
  - instruction=NOP_CODE, instr_valid=0.
  - start=1 -> RUN, pc<=0, end_q<=end_addr.
- RUN, stall=0:
  - instruction<=mem[pc], instr_valid<=1.
  - If pc==end_q: LOOP_EN=1 -> pc<=0, stay in RUN; LOOP_EN=0 -> DONE, pc holds.
  - Else pc<=pc+1.
- RUN, stall=1: instruction<=NOP_CODE, instr_valid<=0, pc holds, state holds.
- RUN, start=1: ignored (no restart).
- DONE:
  - instruction<=NOP_CODE, instr_valid<=0.
  - start=1 -> RUN, pc<=0, end_q<=end_addr.
- abort=1 in any state: next edge -> IDLE, pc<=0, instruction<=NOP_CODE, instr_valid<=0.
- Latency:
  - Start sampled at edge k. First valid instruction (mem[0]) is registered at edge k+1.
  - Last instruction (mem[end_q]) and done=1 appear in the same cycle. instr_valid drops at the next edge.
- Width rules: pc increments modulo 2**ADDR_W. end_q=2**ADDR_W-1 runs the full store.
- end_addr changes during RUN have no effect until the next start.
- Reset mid-RUN: asynchronous return to reset values within the same cycle. The store retains its contents.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN, DONE}.
  - Default constants ADDR_W=4, INSTR_W=4, NOP_CODE=4'h0.
- Sub-module instr_mem: 2**ADDR_W x INSTR_W synchronous-write/synchronous-read array.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - No reset on the array.
- FSM, PC and output registers live in the top module.

Test Plan:
- Load mem[0..3]=4'h1,4'h5,4'hA,4'hF; end_addr=3; pulse start -> instruction 1,5,A,F on four consecutive cycles with instr_valid=1; done=1 with F; next cycle NOP_CODE, valid=0, pc=3.
- Same program, stall=1 for one cycle after the second instruction -> sequence 1,5,NOP(valid=0),A,F; pc holds at 2 during the stall.
- LOOP_EN=1, end_addr=1, mem[0]=3, mem[1]=7 -> repeating 3,7,3,7...; done never asserts; abort -> IDLE, pc=0, valid=0 next cycle.
- In RUN, prog_we=1, prog_addr=2, prog_data=4'h9 -> mem[2] unchanged; on restart from DONE, A is still issued at address 2.
- In IDLE, prog_we writes mem[0]=4'hC in the same cycle as start -> first issued instruction is C.
- rst_n=0 asynchronously mid-RUN at pc=2 -> instruction=NOP_CODE, valid=0, busy=0, pc=0 immediately; after release, start replays the program from address 0 with store contents intact.
